// File: rtl/prirv32_pkg.sv
// Shared constants and the fetch-queue entry type for the priRV32 front end.
package prirv32_pkg;
  localparam int XLEN = 32;
  localparam int ILEN_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/prirv32_fifo.sv
// Synchronous FIFO with flush; flush wins over same-cycle push/pop.
module prirv32_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/prirv32_fetch_unit.sv
// priRV32 fetch front end: PC generation, credit-limited imem requests,
// in-order response queue and redirect handling with stale-response drop.
module prirv32_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(prirv32_pkg::RESET_VECTOR_DEFAULT),
  parameter int              FQ_DEPTH     = 4
) (
  input  logic            clk_in,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);
  import prirv32_pkg::*;

  localparam int              CW      = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0]     CREDITS = (CW+1)'(FQ_DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(ILEN_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc, rsp_pc, redirect_tgt;
  logic [CW-1:0]   inflight, drop, count;
  logic [CW:0]     credit_used;
  logic            req_fire, push, pop, full, empty;
  entry_t          push_entry, head;

  assign redirect_tgt   = redirect_pc & ~XLEN'(3);
  assign credit_used    = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses owed to pre-redirect requests are swallowed while drop is non-zero.
  assign push       = imem_rsp_valid && (drop == '0) && !redirect_valid && !full;
  assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  assign inst_valid = !rst && !empty;
  assign inst_data  = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      fetch_pc <= RESET_VECTOR;
      rsp_pc   <= RESET_VECTOR;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        // Every request still outstanding after this cycle is stale.
        drop     <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (imem_rsp_valid) begin
          if (drop != '0) drop   <= drop - CW'(1);
          else            rsp_pc <= rsp_pc + STEP;
        end
      end
    end
  end

  prirv32_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk_in    (clk_in),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );
endmodule
